// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the SD frame FIFO
// Contents:
//   SD_BLK_BYTES   sector payload size
//   SD_HDR_BYTES   command header size
//   SD_FRAME_BYTES header plus sector, the default FIFO depth
//   cnt_w(depth)   width of an occupancy counter that can hold 0..depth
package fifo_pkg;

    localparam int SD_BLK_BYTES   = 512;
    localparam int SD_HDR_BYTES   = 5;
    localparam int SD_FRAME_BYTES = SD_BLK_BYTES + SD_HDR_BYTES;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port register array, sync write, sync read
// Ports:
//   clk             clock, both ports on its rising edge
//   we/waddr/wdata  write port
//   re/raddr/rdata  read port; rdata is registered and holds while re=0
// No reset: contents and rdata are undefined until written/read.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 517,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A read and a write to the same address in one cycle return the old
    // word; the top relies on this when pushing and popping while full.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_blk.sv
// rtl/sync_fifo_blk.sv - single-clock FIFO with block-threshold and error flags
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   clr               synchronous flush of pointers, count and error flags
//   wr_en, wr_data    push request and data; full when count == DEPTH
//   rd_en             pop request; rd_data/rd_valid valid the cycle after
//   empty, count      occupancy status
//   blk_rdy           count >= BLK_LEN
//   ovf, udf          sticky rejected-push / rejected-pop flags
module sync_fifo_blk
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = SD_FRAME_BYTES,
    parameter int BLK_LEN = SD_BLK_BYTES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    blk_rdy,
    output logic                    ovf,
    output logic                    udf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;
    logic             rd_loaded;
    logic [WIDTH-1:0] ram_rdata;

    // Non-power-of-two depth: wrap by explicit compare.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign blk_rdy = (count_q >= CW'(BLK_LEN));
    assign count   = count_q;

    // A pop frees the slot in the same cycle, so a push while full is fine
    // alongside it. A pop never takes a word pushed in the same cycle.
    assign push_ok = wr_en & (~full | rd_en);
    assign pop_ok  = rd_en & ~empty;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok & ~clr),
        .waddr (wptr),
        .wdata (wr_data),
        .re    (pop_ok & ~clr),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; rd_data reads as zero until the
    // first pop after reset has loaded it.
    assign rd_data = rd_loaded ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            rd_valid  <= 1'b0;
            rd_loaded <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop_ok) begin
                rptr      <= ptr_inc(rptr);
                rd_loaded <= 1'b1;
            end
            rd_valid <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en & full & ~rd_en) begin
                ovf <= 1'b1;
            end
            if (rd_en & empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_blk.sv
// tb/tb_sync_fifo_blk.sv - directed self-checking bench for sync_fifo_blk
module tb_sync_fifo_blk;

    logic clk;
    logic rst_n;

    // Default instance: DEPTH=517, BLK_LEN=512
    logic       b_clr, b_wr, b_rd;
    logic [7:0] b_wd, b_rdata;
    logic       b_full, b_rvalid, b_empty, b_blk, b_ovf, b_udf;
    logic [9:0] b_count;

    // Small instance: DEPTH=5, BLK_LEN=3
    logic       s_clr, s_wr, s_rd;
    logic [7:0] s_wd, s_rdata;
    logic       s_full, s_rvalid, s_empty, s_blk, s_ovf, s_udf;
    logic [2:0] s_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic       seen_ee;

    sync_fifo_blk u_big (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .wr_en    (b_wr),
        .wr_data  (b_wd),
        .full     (b_full),
        .rd_en    (b_rd),
        .rd_data  (b_rdata),
        .rd_valid (b_rvalid),
        .empty    (b_empty),
        .count    (b_count),
        .blk_rdy  (b_blk),
        .ovf      (b_ovf),
        .udf      (b_udf)
    );

    sync_fifo_blk #(.WIDTH(8), .DEPTH(5), .BLK_LEN(3)) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (s_clr),
        .wr_en    (s_wr),
        .wr_data  (s_wd),
        .full     (s_full),
        .rd_en    (s_rd),
        .rd_data  (s_rdata),
        .rd_valid (s_rvalid),
        .empty    (s_empty),
        .count    (s_count),
        .blk_rdy  (s_blk),
        .ovf      (s_ovf),
        .udf      (s_udf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b_clr = 0; b_wr = 0; b_rd = 0; b_wd = 0;
        s_clr = 0; s_wr = 0; s_rd = 0; s_wd = 0;
        seen_ee = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Reset then idle
        chk("rst_rd_data", b_rdata, 0);
        chk("rst_rd_valid", b_rvalid, 0);
        chk("rst_count", b_count, 0);
        chk("rst_empty", b_empty, 1);
        chk("rst_full", b_full, 0);
        chk("rst_blk_rdy", b_blk, 0);
        chk("rst_ovf", b_ovf, 0);
        chk("rst_udf", b_udf, 0);
        chk("rst_small_empty", s_empty, 1);

        // Push 1..5, pop 5 back to back
        b_wr = 1;
        for (int i = 1; i <= 5; i++) begin
            b_wd = 8'(i);
            cyc();
        end
        b_wr = 0;
        chk("basic_count", b_count, 5);
        chk("basic_not_empty", b_empty, 0);
        b_rd = 1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("basic_pop_data", b_rdata, i);
            chk("basic_pop_valid", b_rvalid, 1);
        end
        b_rd = 0;
        cyc();
        chk("basic_valid_drop", b_rvalid, 0);
        chk("basic_empty", b_empty, 1);
        chk("basic_hold_data", b_rdata, 5);

        // Threshold at 512
        b_wr = 1;
        for (int i = 0; i < 511; i++) begin
            b_wd = 8'(i & 8'h7f);
            cyc();
        end
        chk("thr_511_count", b_count, 511);
        chk("thr_511_blk", b_blk, 0);
        cyc();
        b_wr = 0;
        chk("thr_512_count", b_count, 512);
        chk("thr_512_blk", b_blk, 1);
        b_rd = 1;
        cyc();
        b_rd = 0;
        chk("thr_pop_count", b_count, 511);
        chk("thr_pop_blk", b_blk, 0);

        // Fill to DEPTH, overflow, push+pop while full, drain
        b_clr = 1;
        cyc();
        b_clr = 0;
        chk("clr_count", b_count, 0);
        b_wr = 1;
        for (int i = 0; i < 517; i++) begin
            b_wd = 8'(i & 8'h7f);
            q.push_back(8'(i & 8'h7f));
            cyc();
        end
        chk("fill_full", b_full, 1);
        chk("fill_count", b_count, 517);
        chk("fill_ovf_clear", b_ovf, 0);
        b_wd = 8'hEE;
        cyc();
        b_wr = 0;
        chk("ovf_set", b_ovf, 1);
        chk("ovf_count", b_count, 517);
        b_wr = 1; b_wd = 8'hA5; b_rd = 1;
        cyc();
        b_wr = 0;
        exp_d = q.pop_front();
        q.push_back(8'hA5);
        chk("full_pp_data", b_rdata, exp_d);
        chk("full_pp_count", b_count, 517);
        for (int i = 0; i < 517; i++) begin
            cyc();
            exp_d = q.pop_front();
            if (b_rdata == 8'hEE) seen_ee = 1'b1;
            chk("drain_data", b_rdata, exp_d);
        end
        b_rd = 0;
        cyc();
        chk("drain_empty", b_empty, 1);
        chk("drain_no_ee", seen_ee, 0);
        chk("ovf_sticky", b_ovf, 1);
        chk("drain_last_a5", b_rdata, 8'hA5);

        // Flush mid-burst with ovf set; clr overrides wr_en
        b_wr = 1;
        for (int i = 0; i < 10; i++) begin
            b_wd = 8'(8'h40 + i);
            cyc();
        end
        chk("pre_clr_count", b_count, 10);
        chk("pre_clr_ovf", b_ovf, 1);
        b_clr = 1;
        cyc();
        b_clr = 0; b_wr = 0;
        chk("clr_count0", b_count, 0);
        chk("clr_empty", b_empty, 1);
        chk("clr_ovf", b_ovf, 0);
        chk("clr_valid", b_rvalid, 0);
        cyc();
        chk("clr_push_ignored", b_count, 0);

        // Wrap on DEPTH=5: four rounds of push 3 / pop 3
        for (int r = 0; r < 4; r++) begin
            s_wr = 1;
            for (int k = 0; k < 3; k++) begin
                s_wd = 8'(r * 16 + k);
                cyc();
            end
            s_wr = 0;
            s_rd = 1;
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk("wrap_data", s_rdata, r * 16 + k);
            end
            s_rd = 0;
        end
        cyc();
        chk("wrap_empty", s_empty, 1);

        // Small: full, push+pop while full
        s_wr = 1;
        for (int k = 0; k < 5; k++) begin
            s_wd = 8'(8'h60 + k);
            cyc();
        end
        s_wr = 0;
        chk("s_full", s_full, 1);
        chk("s_full_count", s_count, 5);
        chk("s_blk", s_blk, 1);
        s_wr = 1; s_wd = 8'h77; s_rd = 1;
        cyc();
        s_wr = 0;
        chk("s_pp_data", s_rdata, 8'h60);
        chk("s_pp_count", s_count, 5);
        chk("s_pp_ovf", s_ovf, 0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("s_pp_drain", s_rdata, 8'h60 + k);
        end
        cyc();
        s_rd = 0;
        chk("s_pp_last", s_rdata, 8'h77);
        chk("s_pp_empty", s_empty, 1);

        // Small: push+pop while empty
        s_wr = 1; s_wd = 8'h3C; s_rd = 1;
        cyc();
        s_wr = 0; s_rd = 0;
        chk("e_pp_udf", s_udf, 1);
        chk("e_pp_count", s_count, 1);
        chk("e_pp_valid", s_rvalid, 0);
        chk("e_pp_hold", s_rdata, 8'h77);
        s_rd = 1;
        cyc();
        s_rd = 0;
        chk("e_pop_data", s_rdata, 8'h3C);
        chk("e_pop_valid", s_rvalid, 1);
        chk("udf_sticky", s_udf, 1);

        // Asynchronous reset mid-pop
        b_wr = 1;
        for (int i = 0; i < 3; i++) begin
            b_wd = 8'(8'h11 * (i + 1));
            cyc();
        end
        b_wr = 0;
        b_rd = 1;
        cyc();
        chk("mid_pop_data", b_rdata, 8'h11);
        chk("mid_pop_valid", b_rvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", b_rvalid, 0);
        chk("arst_data", b_rdata, 0);
        chk("arst_count", b_count, 0);
        chk("arst_small_udf", s_udf, 0);
        b_rd = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_empty", b_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_blk.md
# sync_fifo_blk

Single-clock, parametrised byte/word FIFO with block-threshold signalling, used between the UART receive path and the SD command/data engine. Buffers one SD frame (command header plus 512-byte sector) and supports arbitrary, non-power-of-two depths. Adds explicit push/pop handshakes, full/empty/occupancy status, a block-ready flag, sticky overflow/underflow error flags and a synchronous flush.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 517, number of entries; any value ≥ 2, need not be a power of two.
- BLK_LEN, 512, occupancy at or above which blk_rdy asserts; 1 ≤ BLK_LEN ≤ DEPTH.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr_en  in  1  push request.
- wr_data  in  WIDTH  push data.
- full  out  1  count == DEPTH.
- rd_en  in  1  pop request.
- rd_data  out  WIDTH  registered pop data.
- rd_valid  out  1  1-cycle pulse; rd_data holds the popped word.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  current occupancy.
- blk_rdy  out  1  count ≥ BLK_LEN.
- ovf  out  1  sticky: a push was rejected.
- udf  out  1  sticky: a pop was rejected.

## Operation
- Pointers wptr/rptr, range 0..DEPTH-1; each wraps from DEPTH-1 to 0 on increment (explicit compare, no power-of-two masking).
- Accepted push = wr_en & (!full | rd_en). A push while full is accepted only when a pop is accepted in the same cycle.
- Accepted pop = rd_en & !empty. No fall-through: a simultaneous push into an empty FIFO does not satisfy the pop.
- On an accepted push: ram[wptr] <= wr_data, and wptr advances.
- On an accepted pop: rd_data <= ram[rptr], rptr advances, and rd_valid pulses the following cycle.
- count: +1 on push only, −1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- Rejected push (wr_en & full & !rd_en) sets ovf; the memory and wptr are untouched.
- Rejected pop (rd_en & empty) sets udf; rd_data holds its value and rd_valid stays 0.
- ovf/udf remain set until clr or reset.
- clr: wptr, rptr and count go to 0, ovf/udf go to 0, and rd_valid goes to 0. clr overrides wr_en/rd_en in the same cycle. Memory contents are not cleared.
- Reset (any time, including mid-burst): same effect as clr, plus rd_data goes to 0.

## Timing
- Reset values: rd_data=0, rd_valid=0, count=0, empty=1, full=0, blk_rdy=0, ovf=0, udf=0.
- Push-to-status latency is 1 cycle: count, full, empty and blk_rdy reflect a push on the edge that accepts it. full, empty and blk_rdy are decoded from registered count.
- Pop latency is 1 cycle: rd_en is sampled at edge N, and rd_data/rd_valid are valid after edge N.
- Back-to-back pops every cycle give one word per cycle, with rd_valid held high.
- Push-to-pop minimum: a word pushed at edge N can be popped at edge N+1, with data appearing after edge N+1.
- ovf/udf assert after the offending edge.

## Structure
- Package fifo_pkg holds:
  - the cnt_w(depth) function (= $clog2(depth+1));
  - constants SD_BLK_BYTES=512, SD_HDR_BYTES=5 and SD_FRAME_BYTES=517, so that the defaults derive from them.
- Sub-module fifo_ram: simple dual-port register array, WIDTH × DEPTH, with synchronous write port (we, waddr, wdata) and synchronous read port (re, raddr, rdata). It has no reset.
- Top level holds the pointers, count, flags and rd_valid.

## Test plan
- Reset then idle: all outputs at reset values. Push 0x01..0x05, pop 5 → rd_data 0x01..0x05 in order, each with a rd_valid pulse; empty=1 at the end.
- DEPTH=517: push 517 words → full=1 and count=517. Push a 518th word → ovf=1, count stays 517. Pop all → the first 517 values in order, and the 518th word never appears.
- Wrap: DEPTH=5; push 3/pop 3 four times → pointers cross 4→0 and data order is preserved every round.
- Simultaneous events: when full, push+pop in one cycle → count unchanged and the new word is read last. When empty, push+pop → udf=1, count=1 and rd_valid=0.
- Threshold: BLK_LEN=512; push 511 words → blk_rdy=0; 512th push → blk_rdy=1 on that edge; one pop → blk_rdy=0.
- Flush and reset mid-burst: after 10 pushes and with ovf set, assert clr with wr_en=1 → count=0, empty=1, ovf=0, and the push is ignored. Assert rst_n low asynchronously mid-pop → rd_valid and rd_data drop to 0 immediately.
